// File: rtl/conv_pkg.sv
// Shared definitions for the convolution sequencer: FSM state encoding and
// geometry helpers used by conv_seq_ctrl, conv_addr_gen and the testbench.
package conv_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  // Width of one padded image row.
  function automatic int pad_w(input int img_w, input int n);
    return img_w + n - 1;
  endfunction

  // Number of flg phases per output pixel.
  function automatic int nph(input int n);
    return 3 * n;
  endfunction

endpackage

// File: rtl/conv_addr_gen.sv
// Row/column pixel counters and registered padded-read / output address generation.
// Addresses are computed from the next row/col so they line up with the registered strobes.
module conv_addr_gen
  import conv_pkg::*;
#(
  parameter int N      = 3,
  parameter int IMG_W  = 256,
  parameter int IMG_H  = 256,
  parameter int ADDR_W = 17
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              adv,
  input  logic              upd,
  input  logic              rd_upd,
  input  logic [ADDR_W-1:0] p,
  output logic [ADDR_W-1:0] rd_addr,
  output logic [ADDR_W-1:0] out_addr,
  output logic              last_pix
);

  localparam int ROW_W = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam int COL_W = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_H - 1);
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_W - 1);
  localparam int PAD_W = pad_w(IMG_W, N);

  logic [ROW_W-1:0] row, row_n;
  logic [COL_W-1:0] col, col_n;

  assign last_pix = (row == ROW_LAST) && (col == COL_LAST);

  // NOTE: every variable gets a default at the top of always_comb so no path leaves it unassigned (no latch).
  always_comb begin
    row_n = row;
    col_n = col;
    if (clr) begin
      row_n = '0;
      col_n = '0;
    end else if (adv) begin
      if (col == COL_LAST) begin
        col_n = '0;
        row_n = row + 1'b1;
      end else begin
        col_n = col + 1'b1;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row      <= '0;
      col      <= '0;
      rd_addr  <= '0;
      out_addr <= '0;
    end else begin
      row <= row_n;
      col <= col_n;
      if (upd) begin
        out_addr <= ADDR_W'(row_n) * ADDR_W'(IMG_W) + ADDR_W'(col_n);
      end
      if (rd_upd) begin
        rd_addr <= (ADDR_W'(row_n) + p) * ADDR_W'(PAD_W) + ADDR_W'(col_n) + ADDR_W'(N - 1);
      end
    end
  end

endmodule

// File: rtl/conv_seq_ctrl.sv
// Sequencer for the systolic convolution array: weight load, per-pixel flg schedule, done.
// Optional CONV_STALL_EN adds an out_ready back-pressure input that holds the schedule at flg==3N-1.
module conv_seq_ctrl
  import conv_pkg::*;
#(
  parameter int N      = 3,
  parameter int IMG_W  = 256,
  parameter int IMG_H  = 256,
  parameter int FLG_W  = 7,
  parameter int ADDR_W = 17
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              w_we,
  output logic [7:0]        w_idx,
  output logic [FLG_W-1:0]  flg,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  output logic              out_valid,
  output logic [ADDR_W-1:0] out_addr
`ifdef CONV_STALL_EN
  ,
  input  logic              out_ready
`endif
);

  localparam int NPH = nph(N);
  localparam logic [FLG_W-1:0] FLG_LAST = FLG_W'(NPH - 1);
  localparam logic [FLG_W-1:0] FLG_N    = FLG_W'(N);
  localparam logic [7:0]       W_LAST   = 8'(N * N - 1);
  localparam longint PAD_CELLS = longint'(IMG_H + N - 1) * longint'(IMG_W + N - 1);

  if (NPH - 1 >= (1 << FLG_W)) begin : g_bad_flg_w
    $error("conv_seq_ctrl: FLG_W cannot hold 3N-1");
  end
  if (PAD_CELLS > (longint'(1) << ADDR_W)) begin : g_bad_addr_w
    $error("conv_seq_ctrl: ADDR_W cannot address the padded image");
  end
  if (N * N > 256) begin : g_bad_n
    $error("conv_seq_ctrl: N*N exceeds the 8-bit w_idx range");
  end

  state_t           state;
  logic [FLG_W-1:0] flg_nxt;
  logic             stall, last_pix, ag_clr, ag_adv, ag_upd, rd_upd;

`ifdef CONV_STALL_EN
  assign stall = out_valid & ~out_ready;
`else
  assign stall = 1'b0;
`endif

  // Address-generator controls track the next flg so rd_addr/out_addr register alongside the strobes.
  always_comb begin
    flg_nxt = flg;
    ag_clr  = 1'b0;
    ag_adv  = 1'b0;
    ag_upd  = 1'b0;
    case (state)
      ST_LOAD: begin
        if (w_idx == W_LAST) begin
          flg_nxt = '0;
          ag_clr  = 1'b1;
          ag_upd  = 1'b1;
        end
      end
      ST_RUN: begin
        if (!stall && !(flg == FLG_LAST && last_pix)) begin
          ag_upd = 1'b1;
          if (flg == FLG_LAST) begin
            flg_nxt = '0;
            ag_adv  = 1'b1;
          end else begin
            flg_nxt = flg + 1'b1;
          end
        end
      end
      default: ;
    endcase
  end

  assign rd_upd = ag_upd && (flg_nxt < FLG_N);

  // NOTE: asynchronous reset clears every control register, aborting a frame without a done pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      w_we      <= 1'b0;
      w_idx     <= '0;
      flg       <= '0;
      rd_en     <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            state <= ST_LOAD;
            busy  <= 1'b1;
            w_we  <= 1'b1;
            w_idx <= '0;
          end
        end
        ST_LOAD: begin
          if (w_idx == W_LAST) begin
            state <= ST_RUN;
            w_we  <= 1'b0;
            flg   <= '0;
            rd_en <= 1'b1;
          end else begin
            w_idx <= w_idx + 1'b1;
          end
        end
        ST_RUN: begin
          if (!stall) begin
            if (flg == FLG_LAST && last_pix) begin
              state     <= ST_DONE;
              busy      <= 1'b0;
              done      <= 1'b1;
              flg       <= '0;
              rd_en     <= 1'b0;
              out_valid <= 1'b0;
            end else begin
              flg       <= flg_nxt;
              rd_en     <= (flg_nxt < FLG_N);
              out_valid <= (flg_nxt == FLG_LAST);
            end
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  conv_addr_gen #(
    .N      (N),
    .IMG_W  (IMG_W),
    .IMG_H  (IMG_H),
    .ADDR_W (ADDR_W)
  ) u_addr_gen (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (ag_clr),
    .adv      (ag_adv),
    .upd      (ag_upd),
    .rd_upd   (rd_upd),
    .p        (ADDR_W'(flg_nxt)),
    .rd_addr  (rd_addr),
    .out_addr (out_addr),
    .last_pix (last_pix)
  );

endmodule

// File: tb/tb_conv_seq_ctrl.sv
// Directed testbench for conv_seq_ctrl with N=3 and a 4x4 image; cycle 0 is the cycle start is driven.
// Build with CONV_STALL_EN defined to also exercise out_ready back-pressure.
module tb_conv_seq_ctrl;
  import conv_pkg::*;

  localparam int N      = 3;
  localparam int IMG_W  = 4;
  localparam int IMG_H  = 4;
  localparam int FLG_W  = 7;
  localparam int ADDR_W = 17;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic              busy, done, w_we, rd_en, out_valid;
  logic [7:0]        w_idx;
  logic [FLG_W-1:0]  flg;
  logic [ADDR_W-1:0] rd_addr, out_addr;
`ifdef CONV_STALL_EN
  logic              out_ready = 1'b1;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  conv_seq_ctrl #(
    .N(N), .IMG_W(IMG_W), .IMG_H(IMG_H), .FLG_W(FLG_W), .ADDR_W(ADDR_W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .busy      (busy),
    .done      (done),
    .w_we      (w_we),
    .w_idx     (w_idx),
    .flg       (flg),
    .rd_en     (rd_en),
    .rd_addr   (rd_addr),
    .out_valid (out_valid),
    .out_addr  (out_addr)
`ifdef CONV_STALL_EN
    ,
    .out_ready (out_ready)
`endif
  );

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if ({busy, done, w_we, rd_en, out_valid} !== 5'b0) begin
      n_bad++;
      $display("FAIL reset_strobes got=%b exp=%b", {busy, done, w_we, rd_en, out_valid}, 5'b0);
    end
    n_cmp++;
    if ({flg, w_idx, rd_addr, out_addr} !== '0) begin
      n_bad++;
      $display("FAIL reset_values flg=%0d w_idx=%0d rd_addr=%0d out_addr=%0d exp all 0",
               flg, w_idx, rd_addr, out_addr);
    end
    rst_n = 1'b1;
  endtask

  // Runs one frame from a start pulse at cycle 0 and checks every cycle against the schedule model.
  // stall_len: cycles out_ready is held low at the first out_valid; extra_starts: pulse start in RUN and DONE.
  task automatic check_frame(input string tag, input int stall_len, input bit extra_starts);
    int   done_t, u, pix, ph, e_flg, e_rd, e_oa, n_px, n_done;
    bit   in_stall;
    logic [4:0] e_s;
    done_t = 154 + stall_len;
    n_px   = 0;
    n_done = 0;
    @(posedge clk); #1;
    start = 1'b1;
    for (int t = 1; t <= done_t + 1; t++) begin
      @(posedge clk); #1;
      start = extra_starts && (t == 50 || t == done_t);
      in_stall = (t >= 18) && (t < 18 + stall_len);
`ifdef CONV_STALL_EN
      out_ready = !in_stall;
`endif
      e_flg = 0; e_rd = -1; e_oa = -1;
      e_s = {(t >= 1 && t < done_t), (t == done_t), (t >= 1 && t <= 9), 1'b0, 1'b0};
      if (t >= 10 && t < done_t) begin
        if (t > 18 && t <= 18 + stall_len) begin
          e_flg = 8; e_s[0] = 1'b1; e_oa = 0;
        end else begin
          u   = t - 10 - ((t > 18) ? stall_len : 0);
          pix = u / 9;
          ph  = u % 9;
          e_flg = ph;
          e_s[1] = (ph < 3);
          e_s[0] = (ph == 8);
          if (ph < 3)  e_rd = ((pix / IMG_W) + ph) * (IMG_W + N - 1) + (pix % IMG_W) + N - 1;
          if (ph == 8) e_oa = pix;
        end
      end
      n_cmp++;
      if ({busy, done, w_we, rd_en, out_valid} !== e_s) begin
        n_bad++;
        $display("FAIL %s strobes t=%0d got=%b exp=%b (busy,done,w_we,rd_en,out_valid)",
                 tag, t, {busy, done, w_we, rd_en, out_valid}, e_s);
      end
      n_cmp++;
      if (flg !== FLG_W'(e_flg)) begin
        n_bad++;
        $display("FAIL %s flg t=%0d got=%0d exp=%0d", tag, t, flg, e_flg);
      end
      if (t >= 1 && t <= 9) begin
        n_cmp++;
        if (w_idx !== 8'(t - 1)) begin
          n_bad++;
          $display("FAIL %s w_idx t=%0d got=%0d exp=%0d", tag, t, w_idx, t - 1);
        end
      end
      if (e_rd >= 0) begin
        n_cmp++;
        if (rd_addr !== ADDR_W'(e_rd)) begin
          n_bad++;
          $display("FAIL %s rd_addr t=%0d got=%0d exp=%0d", tag, t, rd_addr, e_rd);
        end
      end
      if (e_oa >= 0) begin
        n_cmp++;
        if (out_addr !== ADDR_W'(e_oa)) begin
          n_bad++;
          $display("FAIL %s out_addr t=%0d got=%0d exp=%0d", tag, t, out_addr, e_oa);
        end
      end
      if (out_valid === 1'b1 && !in_stall) n_px++;
      if (done === 1'b1) n_done++;
    end
    start = 1'b0;
    n_cmp++;
    if (n_px != IMG_W * IMG_H) begin
      n_bad++;
      $display("FAIL %s pixel_count got=%0d exp=%0d", tag, n_px, IMG_W * IMG_H);
    end
    n_cmp++;
    if (n_done != 1) begin
      n_bad++;
      $display("FAIL %s done_count got=%0d exp=1", tag, n_done);
    end
  endtask

  // Frame with ignored starts, restart at cycle 155, then asynchronous reset 40 cycles into the new frame.
  task automatic test_back_to_back();
    check_frame("ignore_start", 0, 1'b1);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    n_cmp++;
    if ({busy, w_we, w_idx} !== {1'b1, 1'b1, 8'd0}) begin
      n_bad++;
      $display("FAIL restart got busy=%b w_we=%b w_idx=%0d exp busy=1 w_we=1 w_idx=0", busy, w_we, w_idx);
    end
    for (int t = 2; t <= 40; t++) begin
      @(posedge clk); #1;
    end
    n_cmp++;
    if ({busy, rd_addr} !== {1'b1, ADDR_W'(17)}) begin
      n_bad++;
      $display("FAIL pre_abort got busy=%b rd_addr=%0d exp busy=1 rd_addr=17", busy, rd_addr);
    end
    #1 rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({busy, done, w_we, rd_en, out_valid} !== 5'b0) begin
      n_bad++;
      $display("FAIL abort_strobes got=%b exp=%b", {busy, done, w_we, rd_en, out_valid}, 5'b0);
    end
    n_cmp++;
    if ({flg, rd_addr, out_addr} !== '0) begin
      n_bad++;
      $display("FAIL abort_values flg=%0d rd_addr=%0d out_addr=%0d exp all 0", flg, rd_addr, out_addr);
    end
    repeat (3) begin
      @(posedge clk); #1;
      n_cmp++;
      if (done !== 1'b0) begin
        n_bad++;
        $display("FAIL abort_no_done got=%b exp=0", done);
      end
    end
    rst_n = 1'b1;
  endtask

  initial begin
    test_reset();
    check_frame("frame", 0, 1'b0);
    test_back_to_back();
    check_frame("after_abort", 0, 1'b0);
`ifdef CONV_STALL_EN
    check_frame("stall", 5, 1'b0);
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
